// File: rtl/craft_round_ctrl.sv
// Round sequencer for the iterative CRAFT-64 engine: IDLE -> LOAD -> ROUND x NUM_ROUNDS -> DONE.
// Optional CRAFT_DECRYPT_EN adds the dec input and rc_dir output for descending round order.
module craft_round_ctrl #(
  parameter int NUM_ROUNDS = 32,
  parameter int ROUND_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
`ifdef CRAFT_DECRYPT_EN
  input  logic               dec,
  output logic               rc_dir,
`endif
  output logic               ready,
  output logic               busy,
  output logic               state_load,
  output logic               state_en,
  output logic [ROUND_W-1:0] round,
  output logic               last_round,
  output logic               rc_init,
  output logic               rc_ce,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_DONE} state_t;

  localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(NUM_ROUNDS - 1);

  state_t             state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               dir_q, dir_d;
  logic               busy_q, busy_d;
  logic               load_q, load_d;
  logic               en_q, en_d;
  logic               last_q, last_d;
  logic               rcinit_q, rcinit_d;
  logic               rcce_q, rcce_d;
  logic               valid_q, valid_d;
  logic               accept;
  logic [ROUND_W-1:0] first_idx, end_idx;

  assign first_idx = dir_q ? LAST_IDX : '0;
  assign end_idx   = dir_q ? '0 : LAST_IDX;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start) begin
                 state_d = S_LOAD;
                 accept  = 1'b1;
               end
      S_LOAD:  state_d = S_ROUND;
      S_ROUND: if (round_q == end_idx) state_d = S_DONE;
      S_DONE:  if (out_ready) begin
                 state_d = start ? S_LOAD : S_IDLE;
                 accept  = start;
               end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      accept  = 1'b0;
    end

    dir_d = dir_q;
`ifdef CRAFT_DECRYPT_EN
    if (accept) dir_d = dec;
`else
    dir_d = 1'b0;
`endif
    if (state_d == S_IDLE) dir_d = 1'b0;

    // The counter doubles as the round output, so it is zero outside ROUND.
    round_d = '0;
    if (state_d == S_ROUND) begin
      if (state_q == S_LOAD) round_d = first_idx;
      else if (dir_q)        round_d = round_q - ROUND_W'(1);
      else                   round_d = round_q + ROUND_W'(1);
    end

    busy_d   = (state_d == S_LOAD) || (state_d == S_ROUND);
    load_d   = (state_d == S_LOAD);
    rcinit_d = (state_d == S_LOAD);
    en_d     = (state_d == S_ROUND);
    last_d   = (state_d == S_ROUND) && (round_d == end_idx);
    rcce_d   = (state_d == S_ROUND) && (round_d != end_idx);
    valid_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      round_q  <= '0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      load_q   <= 1'b0;
      en_q     <= 1'b0;
      last_q   <= 1'b0;
      rcinit_q <= 1'b0;
      rcce_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      load_q   <= load_d;
      en_q     <= en_d;
      last_q   <= last_d;
      rcinit_q <= rcinit_d;
      rcce_q   <= rcce_d;
      valid_q  <= valid_d;
    end
  end

  // ready in DONE follows out_ready so a new start can be taken on the handshake cycle.
  assign ready      = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign busy       = busy_q;
  assign state_load = load_q;
  assign state_en   = en_q;
  assign round      = round_q;
  assign last_round = last_q;
  assign rc_init    = rcinit_q;
  assign rc_ce      = rcce_q;
  assign out_valid  = valid_q;
`ifdef CRAFT_DECRYPT_EN
  assign rc_dir     = dir_q;
`endif

endmodule

// File: tb/tb_craft_round_ctrl.sv
// Self-checking bench for craft_round_ctrl: checkpoint table, directed corner sequences and
// randomized traffic against a block-timeline reference model.
module tb_craft_round_ctrl;
  localparam int N  = 32;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, abort = 1'b0, out_ready = 1'b0, dec = 1'b0;
  logic          ready_w, busy_w, load_w, en_w, last_w, rcinit_w, rcce_w, valid_w, rc_dir_w;
  logic [RW-1:0] round_w;

  craft_round_ctrl #(.NUM_ROUNDS(N), .ROUND_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
`ifdef CRAFT_DECRYPT_EN
    .dec(dec), .rc_dir(rc_dir_w),
`endif
    .ready(ready_w), .busy(busy_w), .state_load(load_w), .state_en(en_w),
    .round(round_w), .last_round(last_w), .rc_init(rcinit_w), .rc_ce(rcce_w),
    .out_valid(valid_w), .out_ready(out_ready)
  );
`ifndef CRAFT_DECRYPT_EN
  assign rc_dir_w = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  bit m_active = 1'b0;
  int m_t0 = 0;
  bit m_dec = 1'b0;

  typedef struct { int c; logic [16:0] e; } cp_t;
  cp_t table_q[$];

  function automatic logic [16:0] mk(bit rdir, bit rdy, bit bsy, bit ld, bit en, int rnd,
                                     bit last, bit ri, bit rce, bit v);
    logic [RW-1:0] r8;
    r8 = RW'(rnd);
    return {rdir, rdy, bsy, ld, en, r8, last, ri, rce, v};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {rc_dir_w, ready_w, busy_w, load_w, en_w, round_w, last_w, rcinit_w, rcce_w, valid_w};
  endfunction

  // Timeline model: offset 0 after the accepting edge is LOAD, 1..N are rounds, then DONE.
  function automatic logic [16:0] model_exp();
    int  off, k;
    bit  done, rdy;
    off  = cyc - m_t0;
    done = m_active && (off >= N + 1);
    rdy  = !m_active || (done && out_ready);
    if (!m_active) return mk(0, rdy, 0, 0, 0, 0, 0, 0, 0, 0);
    if (off == 0)  return mk(m_dec, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    if (off <= N) begin
      k = off - 1;
      return mk(m_dec, 0, 1, 0, 1, m_dec ? N - 1 - k : k, k == N - 1, 0, k < N - 1, 0);
    end
    return mk(m_dec, rdy, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  task automatic model_edge();
    int off;
    bit done;
    off  = cyc - m_t0;
    done = m_active && (off >= N + 1);
    if (!rst) m_active = 1'b0;
    else if (abort) m_active = 1'b0;
    else if (!m_active || (done && out_ready)) begin
      if (start) begin
        m_active = 1'b1;
        m_t0     = cyc + 1;
        m_dec    = dec;
      end else m_active = 1'b0;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check("model", 32'(dut_vec()), 32'(model_exp()));
  endtask

  task automatic wait_valid(int budget, output bit ok);
    int n = 0;
    while (!valid_w && n < budget) begin step(); n++; end
    ok = valid_w;
    if (!ok) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_round(int r, int budget);
    int n = 0;
    while (!(en_w && round_w == RW'(r)) && n < budget) begin step(); n++; end
    if (!(en_w && round_w == RW'(r))) check("wait_round_timeout", 32'(round_w), 32'(r));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    bit ok;
    int v1;
    logic [16:0] idle_v;
    idle_v = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    table_q.push_back('{1,  mk(0, 0, 1, 1, 0, 0,  0, 1, 0, 0)});
    table_q.push_back('{2,  mk(0, 0, 1, 0, 1, 0,  0, 0, 1, 0)});
    table_q.push_back('{3,  mk(0, 0, 1, 0, 1, 1,  0, 0, 1, 0)});
    table_q.push_back('{17, mk(0, 0, 1, 0, 1, 15, 0, 0, 1, 0)});
    table_q.push_back('{32, mk(0, 0, 1, 0, 1, 30, 0, 0, 1, 0)});
    table_q.push_back('{33, mk(0, 0, 1, 0, 1, 31, 1, 0, 0, 0)});
    table_q.push_back('{34, mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 1)});
    table_q.push_back('{35, idle_v});

    #12;
    check("reset_state", 32'(dut_vec()), 32'(idle_v));
    @(posedge clk); #1;
    rst = 1'b1;

    // Nominal block, consumer always ready; cycle c observed after edge E0+c-1.
    out_ready = 1'b1;
    pulse_start();
    for (int c = 1; c <= 35; c++) begin
      foreach (table_q[i])
        if (table_q[i].c == c) check($sformatf("table_c%0d", c), 32'(dut_vec()), 32'(table_q[i].e));
      if (c < 35) step();
    end

    // Reset mid-ROUND discards the block.
    pulse_start();
    wait_round(12, 40);
    rst = 1'b0;
    m_active = 1'b0;
    #1;
    check("async_reset", 32'(dut_vec()), 32'(idle_v));
    repeat (2) step();
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (valid_w) check("valid_after_reset", 32'(valid_w), 32'd0);
    end

    // Stalled consumer: result held, start ignored.
    out_ready = 1'b0;
    pulse_start();
    wait_valid(60, ok);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(valid_w), 32'd1);
      check("hold_en", 32'(en_w), 32'd0);
      start = 1'b1;
      step();
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    check("release_valid", 32'(valid_w), 32'd0);
    check("release_ready", 32'(ready_w), 32'd1);

    // Back-to-back: start on the handshake cycle goes straight to LOAD.
    pulse_start();
    wait_valid(60, ok);
    v1 = cyc;
    pulse_start();
    check("b2b_load", 32'(load_w), 32'd1);
    wait_valid(60, ok);
    check("b2b_spacing", 32'(cyc - v1), 32'(N + 2));
    step();

    // Abort beats a simultaneous start; the next block is complete.
    pulse_start();
    wait_round(5, 40);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("abort_idle", 32'(dut_vec()), 32'(idle_v));
    repeat (40) step();
    pulse_start();
    v1 = cyc;
    step();
    check("after_abort_r0", 32'({en_w, round_w}), 32'({1'b1, 8'd0}));
    wait_valid(60, ok);
    check("after_abort_latency", 32'(cyc - v1), 32'(N + 1));
    step();

`ifdef CRAFT_DECRYPT_EN
    dec = 1'b1;
    pulse_start();
    v1 = cyc;
    dec = 1'b0;
    check("dec_rc_dir", 32'(rc_dir_w), 32'd1);
    step();
    check("dec_first_round", 32'(round_w), 32'(N - 1));
    while (!last_w && cyc - v1 < 40) step();
    check("dec_last_round_idx", 32'({last_w, round_w}), 32'({1'b1, 8'd0}));
    wait_valid(10, ok);
    check("dec_latency", 32'(cyc - v1), 32'(N + 1));
    step();
`endif

    // Randomized traffic against the timeline model.
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom % 4) == 0;
      abort     = ($urandom % 40) == 0;
      out_ready = ($urandom % 3) != 0;
      rst       = ($urandom % 500) != 0;
`ifdef CRAFT_DECRYPT_EN
      dec       = $urandom % 2;
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
